// File: rtl/sar_track_ctrl.sv
// sar_track_ctrl
//   Successive-approximation and tracking controller for the SAR timer stage.
//   First it runs a binary search on CompC. Then it holds the code and moves it
//   by one LSB at a time, following the window comparators CompI and CompD.
//   It also counts consecutive steps in the same direction. When that run gets
//   too long, the controller gives up tracking and starts a fresh conversion.
//
// Ports
//   ClockT      clock, all state changes on its rising edge
//   Reset       synchronous, active-high, highest priority
//   Restart     synchronous re-conversion request (level-sampled)
//   CompC       1 = input >= DAC(SAROut), used while deciding a SAR bit
//   CompI       1 = input above upper window (code must go up)
//   CompD       1 = input below lower window (code must go down)
//   SAROut      current trial / tracked code (registered)
//   StateP      10 settle, 01 decide, 00 track, 11 step (registered)
//   Inc / Dcr   high only during the step cycle of an up / down step
//   Busy        high while converting (StateP is 10 or 01)
//   LossOfLock  one-cycle pulse when a forced relock starts

module sar_track_ctrl #(
    parameter int DATA       = 8,
    parameter int SETTLE     = 2,
    parameter int STEP_LIMIT = 4
) (
    input  logic            ClockT,
    input  logic            Reset,
    input  logic            Restart,
    input  logic            CompC,
    input  logic            CompI,
    input  logic            CompD,
    output logic [DATA-1:0] SAROut,
    output logic [1:0]      StateP,
    output logic            Inc,
    output logic            Dcr,
    output logic            Busy,
    output logic            LossOfLock
);

    localparam int PTR_W = (DATA > 1) ? $clog2(DATA) : 1;
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int RUN_W = $clog2(STEP_LIMIT + 1);

    localparam logic [DATA-1:0]  MID_CODE = DATA'(1) << (DATA - 1);
    localparam logic [PTR_W-1:0] PTR_TOP  = PTR_W'(DATA - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(STEP_LIMIT);

    typedef enum logic [1:0] {
        ST_SETTLE = 2'b10,
        ST_DECIDE = 2'b01,
        ST_TRACK  = 2'b00,
        ST_STEP   = 2'b11
    } state_t;

    state_t           state;
    logic [PTR_W-1:0] ptr;
    logic [CNT_W-1:0] cnt;
    logic [RUN_W-1:0] run;
    logic             lastUp;     // direction of the most recent track step
    logic [DATA-1:0]  decideCode;
    logic             upReq;
    logic             dnReq;
    logic             sameDir;

    // Saturation guards: these keep a track step from ever wrapping the code.
    function automatic logic atTop(input logic [DATA-1:0] code);
        return &code;
    endfunction

    function automatic logic atBottom(input logic [DATA-1:0] code);
        return code == '0;
    endfunction

    // Decide the current bit. If more bits remain, also raise the next trial bit.
    always_comb begin
        decideCode = SAROut;
        if (!CompC) decideCode[ptr] = 1'b0;
        if (ptr != '0) decideCode[ptr - PTR_W'(1)] = 1'b1;
    end

    // A request that would saturate the code counts as neither up nor down.
    // Run is therefore held in that case, not cleared.
    assign upReq   = CompI & ~CompD & ~atTop(SAROut);
    assign dnReq   = CompD & ~CompI & ~atBottom(SAROut);
    assign sameDir = (upReq == lastUp);

    always_ff @(posedge ClockT) begin
        if (Reset || Restart) begin
            state      <= ST_SETTLE;
            SAROut     <= MID_CODE;
            ptr        <= PTR_TOP;
            cnt        <= CNT_LOAD;
            run        <= '0;
            lastUp     <= 1'b0;
            Inc        <= 1'b0;
            Dcr        <= 1'b0;
            LossOfLock <= 1'b0;
        end else begin
            Inc        <= 1'b0;
            Dcr        <= 1'b0;
            LossOfLock <= 1'b0;
            case (state)
                ST_SETTLE: begin
                    if (cnt == '0) state <= ST_DECIDE;
                    else           cnt   <= cnt - CNT_W'(1);
                end
                ST_DECIDE: begin
                    SAROut <= decideCode;
                    cnt    <= CNT_LOAD;
                    if (ptr != '0) begin
                        ptr   <= ptr - PTR_W'(1);
                        state <= ST_SETTLE;
                    end else begin
                        run   <= '0;
                        state <= ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    // The comparators are looked at only after the DAC has settled.
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (upReq || dnReq) begin
                        if (sameDir && (run == RUN_MAX)) begin
                            // Too many steps in one direction: drop lock and reconvert.
                            LossOfLock <= 1'b1;
                            state      <= ST_SETTLE;
                            SAROut     <= MID_CODE;
                            ptr        <= PTR_TOP;
                            cnt        <= CNT_LOAD;
                            run        <= '0;
                        end else begin
                            state  <= ST_STEP;
                            Inc    <= upReq;
                            Dcr    <= dnReq;
                            run    <= sameDir ? run + RUN_W'(1) : RUN_W'(1);
                            lastUp <= upReq;
                        end
                    end else if (!(CompI ^ CompD)) begin
                        // Input is inside the window, or the comparators disagree.
                        run <= '0;
                    end
                end
                ST_STEP: begin
                    SAROut <= Inc ? SAROut + DATA'(1) : SAROut - DATA'(1);
                    cnt    <= CNT_LOAD;
                    state  <= ST_TRACK;
                end
            endcase
        end
    end

    assign StateP = state;
    assign Busy   = (state == ST_SETTLE) || (state == ST_DECIDE);

endmodule

// File: tb/tb_sar_track_ctrl.sv
// tb_sar_track_ctrl
//   Directed bench for sar_track_ctrl with the default parameters
//   (DATA=8, SETTLE=2, STEP_LIMIT=4). The bench models CompC as Vin >= SAROut
//   for conversions. Tracking behaviour is checked row by row from a table of
//   hand-computed expectations.

module tb_sar_track_ctrl;

    logic       ClockT;
    logic       Reset;
    logic       Restart;
    logic       compC;
    logic       compI;
    logic       compD;
    logic [7:0] sarOut;
    logic [1:0] stateP;
    logic       inc;
    logic       dcr;
    logic       busy;
    logic       lossOfLock;

    logic [7:0] vin;
    int         nChecks;
    int         nPass;

    sar_track_ctrl dut (
        .ClockT     (ClockT),
        .Reset      (Reset),
        .Restart    (Restart),
        .CompC      (compC),
        .CompI      (compI),
        .CompD      (compD),
        .SAROut     (sarOut),
        .StateP     (stateP),
        .Inc        (inc),
        .Dcr        (dcr),
        .Busy       (busy),
        .LossOfLock (lossOfLock)
    );

    initial ClockT = 1'b0;
    always #5 ClockT = ~ClockT;

    typedef struct {
        logic       compI;
        logic       compD;
        logic [7:0] sar;
        logic [1:0] st;
        logic       inc;
        logic       dcr;
        logic       lol;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic ci, input logic cd, input logic [7:0] s,
                                input logic [1:0] st, input logic i, input logic d,
                                input logic l);
        vec_t v;
        v.compI = ci; v.compD = cd; v.sar = s; v.st = st;
        v.inc = i; v.dcr = d; v.lol = l;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Advance one clock, sample just after the edge, then update the CompC model.
    task automatic tick();
        @(posedge ClockT);
        #1;
        compC = (vin >= sarOut);
    endtask

    task automatic convert(input logic [7:0] v);
        vin   = v;
        compC = (vin >= sarOut);
        repeat (24) tick();
    endtask

    task automatic restartPulse();
        Restart = 1'b1;
        tick();
        Restart = 1'b0;
        check("restart code", sarOut, 8'h80);
        check("restart state", stateP, 2'b10);
    endtask

    task automatic runRows(input int first, input int last);
        for (int i = first; i < last; i++) begin
            logic expBusy;
            compI = tbl[i].compI;
            compD = tbl[i].compD;
            tick();
            expBusy = (tbl[i].st == 2'b10) || (tbl[i].st == 2'b01);
            check($sformatf("row%0d {sar,st,inc,dcr,lol,busy}", i),
                  {18'd0, sarOut, stateP, inc, dcr, lossOfLock, busy},
                  {18'd0, tbl[i].sar, tbl[i].st, tbl[i].inc, tbl[i].dcr, tbl[i].lol, expBusy});
        end
        compI = 1'b0;
        compD = 1'b0;
    endtask

    int sec2, sec3a, sec3b, sec4, secEnd;

    initial begin
        nChecks = 0; nPass = 0;
        Reset = 1'b1; Restart = 1'b0;
        compC = 1'b0; compI = 1'b0; compD = 1'b0; vin = 8'h00;

        // Expectation tables
        sec2 = tbl.size();           // locked at 0x40, CompI held high
        add(1, 0, 8'h40, 2'b00, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            add(1, 0, 8'h40 + 8'(k), 2'b11, 1, 0, 0);
            add(1, 0, 8'h41 + 8'(k), 2'b00, 0, 0, 0);
            add(1, 0, 8'h41 + 8'(k), 2'b00, 0, 0, 0);
        end
        add(1, 0, 8'h80, 2'b10, 0, 0, 1);   // fifth request forces relock
        add(0, 0, 8'h80, 2'b10, 0, 0, 0);
        add(0, 0, 8'h80, 2'b01, 0, 0, 0);
        sec3a = tbl.size();          // locked at 0xFF, up request saturated
        for (int k = 0; k < 6; k++) add(1, 0, 8'hFF, 2'b00, 0, 0, 0);
        sec3b = tbl.size();          // locked at 0x00, down request saturated
        for (int k = 0; k < 6; k++) add(0, 1, 8'h00, 2'b00, 0, 0, 0);
        sec4 = tbl.size();           // locked at 0x30: both high, then alternation
        for (int k = 0; k < 4; k++) add(1, 1, 8'h30, 2'b00, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            add(1, 0, 8'h30, 2'b11, 1, 0, 0);
            add(0, 1, 8'h31, 2'b00, 0, 0, 0);
            add(0, 1, 8'h31, 2'b00, 0, 0, 0);
            add(0, 1, 8'h31, 2'b11, 0, 1, 0);
            add(1, 0, 8'h30, 2'b00, 0, 0, 0);
            add(1, 0, 8'h30, 2'b00, 0, 0, 0);
        end
        secEnd = tbl.size();

        // Reset state
        tick(); tick();
        check("reset code", sarOut, 8'h80);
        check("reset state", stateP, 2'b10);
        check("reset busy", busy, 1'b1);
        check("reset inc", inc, 1'b0);
        check("reset dcr", dcr, 1'b0);
        check("reset lol", lossOfLock, 1'b0);

        // Conversion of 0xA5 finishes exactly at cycle 24
        Reset = 1'b0;
        vin   = 8'hA5;
        compC = (vin >= sarOut);
        repeat (23) tick();
        check("cycle23 state", stateP, 2'b01);
        check("cycle23 busy", busy, 1'b1);
        tick();
        check("conv A5 code", sarOut, 8'hA5);
        check("conv A5 state", stateP, 2'b00);
        check("conv A5 busy", busy, 1'b0);

        // Run limit and forced relock
        restartPulse();
        convert(8'h40);
        check("conv 40 code", sarOut, 8'h40);
        runRows(sec2, sec3a);

        // Saturation at both ends
        restartPulse();
        convert(8'hFF);
        check("conv FF code", sarOut, 8'hFF);
        runRows(sec3a, sec3b);
        restartPulse();
        convert(8'h00);
        check("conv 00 code", sarOut, 8'h00);
        runRows(sec3b, sec4);

        // Window straddle and alternating steps
        restartPulse();
        convert(8'h30);
        check("conv 30 code", sarOut, 8'h30);
        runRows(sec4, secEnd);

        // Restart in the middle of a conversion
        restartPulse();
        vin   = 8'h3C;
        compC = (vin >= sarOut);
        repeat (10) tick();
        Restart = 1'b1;
        tick();
        Restart = 1'b0;
        check("mid restart state", stateP, 2'b10);
        check("mid restart code", sarOut, 8'h80);
        convert(8'h5A);
        check("reconv 5A code", sarOut, 8'h5A);
        check("reconv 5A state", stateP, 2'b00);

        // Reset while in the step state
        compI = 1'b1;
        tick();
        tick();
        check("step state", stateP, 2'b11);
        check("step inc", inc, 1'b1);
        Reset = 1'b1;
        tick();
        check("reset in step code", sarOut, 8'h80);
        check("reset in step state", stateP, 2'b10);
        check("reset in step inc", inc, 1'b0);
        check("reset in step lol", lossOfLock, 1'b0);
        Reset = 1'b0;
        compI = 1'b0;

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
